// File: rtl/switch_rr_scheduler.sv
// Round-robin scheduler and output-flow controller for one router switch.
// Arbitrates the ACK FIFO and input ports 0-2. It moves one packet at a time
// to output port 0 (local), 1 (src-1) or 2 (src+1). Packets that cannot be
// routed, or that stall too long on a full output, are dropped and counted.
module switch_rr_scheduler #(
  parameter int ROUTER_WIDTH = 2,
  parameter int AURORA_WIDTH = 256,
  parameter int RD_LATENCY   = 1,
  parameter int STALL_LIMIT  = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ROUTER_WIDTH-1:0]   src_router,
  input  logic [3:0]                empty_in,
  output logic [3:0]                rd_in,
  input  logic [4*AURORA_WIDTH-1:0] data_in,
  input  logic [2:0]                full_out,
  output logic [2:0]                we_out,
  output logic [AURORA_WIDTH-1:0]   data_out,
  output logic [ROUTER_WIDTH-1:0]   pkt_dst_router,
  input  logic [ROUTER_WIDTH-1:0]   next_router,
  output logic [1:0]                grant_id,
  output logic                      busy,
  output logic [15:0]               drop_count
);

  localparam int WCW = $clog2(RD_LATENCY + 1);
  localparam int SCW = $clog2(STALL_LIMIT + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_ROUTE,
    ST_SEND
  } state_t;

  state_t                    state, state_d;
  logic [1:0]                ptr;
  logic [1:0]                target;
  logic [WCW-1:0]            wait_cnt;
  logic [SCW-1:0]            stall_cnt;
  logic [AURORA_WIDTH-1:0]   data_reg;

  logic                      found;
  logic [1:0]                pick;
  logic [1:0]                idx;
  logic                      route_ok;
  logic [1:0]                route_port;
  logic                      full_sel;
  logic                      drop;
  logic [ROUTER_WIDTH-1:0]   src_plus;
  logic [ROUTER_WIDTH-1:0]   src_minus;

  assign src_plus       = src_router + ROUTER_WIDTH'(1);
  assign src_minus      = src_router - ROUTER_WIDTH'(1);
  assign pkt_dst_router = data_reg[ROUTER_WIDTH+1:2];
  assign busy           = (state != ST_IDLE);

  // Next-state decode: round-robin search, route lookup and drop decisions.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d    = state;
    found      = 1'b0;
    pick       = ptr;
    idx        = 2'd0;
    route_ok   = 1'b0;
    route_port = 2'd0;
    full_sel   = 1'b1;
    drop       = 1'b0;

    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && !empty_in[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end

    // +1 is checked first so it wins when ROUTER_WIDTH=1 makes +1 equal -1.
    if (next_router == src_plus) begin
      route_ok   = 1'b1;
      route_port = 2'd2;
    end else if (next_router == src_minus) begin
      route_ok   = 1'b1;
      route_port = 2'd1;
    end else if (next_router == src_router) begin
      route_ok   = 1'b1;
      route_port = 2'd0;
    end

    case (target)
      2'd0:    full_sel = full_out[0];
      2'd1:    full_sel = full_out[1];
      2'd2:    full_sel = full_out[2];
      default: full_sel = 1'b1;
    endcase

    case (state)
      ST_IDLE:  if (found) state_d = ST_READ;
      ST_READ:  state_d = ST_WAIT;
      ST_WAIT:  if (wait_cnt == '0) state_d = ST_ROUTE;
      ST_ROUTE: begin
        if (route_ok) begin
          state_d = ST_SEND;
        end else begin
          state_d = ST_IDLE;
          drop    = 1'b1;
        end
      end
      ST_SEND: begin
        if (!full_sel) begin
          state_d = ST_IDLE;
        end else if (stall_cnt == SCW'(STALL_LIMIT - 1)) begin
          state_d = ST_IDLE;
          drop    = 1'b1;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, datapath and registered outputs; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: data_reg is reset too because pkt_dst_router decodes it and must read 0 after reset.
      state      <= ST_IDLE;
      ptr        <= 2'd0;
      target     <= 2'd0;
      wait_cnt   <= '0;
      stall_cnt  <= '0;
      data_reg   <= '0;
      rd_in      <= 4'b0000;
      we_out     <= 3'b000;
      data_out   <= '0;
      grant_id   <= 2'd0;
      drop_count <= 16'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state    <= state_d;
      rd_in    <= 4'b0000;
      we_out   <= 3'b000;
      data_out <= '0;

      case (state)
        ST_IDLE: begin
          if (found) begin
            grant_id <= pick;
            rd_in    <= 4'b0001 << pick;
            ptr      <= pick + 2'd1;
          end
        end
        ST_READ:  wait_cnt <= WCW'(RD_LATENCY - 1);
        ST_WAIT: begin
          wait_cnt <= wait_cnt - WCW'(1);
          if (wait_cnt == '0)
            data_reg <= data_in[int'(grant_id)*AURORA_WIDTH +: AURORA_WIDTH];
        end
        ST_ROUTE: begin
          target    <= route_port;
          stall_cnt <= '0;
        end
        ST_SEND: begin
          if (!full_sel) begin
            we_out   <= 3'b001 << target;
            data_out <= data_reg;
          end else begin
            stall_cnt <= stall_cnt + SCW'(1);
          end
        end
        default: ;
      endcase

      if (drop && drop_count != 16'hFFFF)
        drop_count <= drop_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_switch_rr_scheduler.sv
// Directed bench for switch_rr_scheduler. A second instance with a short
// stall limit covers the stall-drop path; it has its own full flags.
module tb_switch_rr_scheduler;

  localparam int RW = 2;
  localparam int AW = 256;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [RW-1:0]   src_router = '0;
  logic [3:0]      empty_in = 4'hF;
  logic [4*AW-1:0] data_in;
  logic [2:0]      full_out = 3'b000;
  logic [2:0]      full_out_s = 3'b000;
  logic [RW-1:0]   next_router = '0;

  logic [3:0]      rd_in, rd_in_s;
  logic [2:0]      we_out, we_out_s;
  logic [AW-1:0]   data_out, data_out_s;
  logic [RW-1:0]   pkt_dst_router, pkt_dst_router_s;
  logic [1:0]      grant_id, grant_id_s;
  logic            busy, busy_s;
  logic [15:0]     drop_count, drop_count_s;

  logic [AW-1:0]   pkt [4];
  int              total = 0;
  int              bad = 0;
  int              cyc = 0;
  int              last_rd = 0;

  // Packets: low nibble 4'h8 puts 2'b10 in the destination field of each.
  assign pkt[0] = {8{32'hA5A5_5A58}};
  assign pkt[1] = {8{32'h1111_2228}};
  assign pkt[2] = {8{32'h3C3C_C3C8}};
  assign pkt[3] = {8{32'h0F0F_F0F8}};
  assign data_in = {pkt[3], pkt[2], pkt[1], pkt[0]};

  always #5 clk = ~clk;

  switch_rr_scheduler #(.ROUTER_WIDTH(RW), .AURORA_WIDTH(AW), .RD_LATENCY(1), .STALL_LIMIT(255)) dut (
    .clk(clk), .rst(rst), .src_router(src_router), .empty_in(empty_in), .rd_in(rd_in),
    .data_in(data_in), .full_out(full_out), .we_out(we_out), .data_out(data_out),
    .pkt_dst_router(pkt_dst_router), .next_router(next_router), .grant_id(grant_id),
    .busy(busy), .drop_count(drop_count)
  );

  switch_rr_scheduler #(.ROUTER_WIDTH(RW), .AURORA_WIDTH(AW), .RD_LATENCY(1), .STALL_LIMIT(4)) dut_s (
    .clk(clk), .rst(rst), .src_router(src_router), .empty_in(empty_in), .rd_in(rd_in_s),
    .data_in(data_in), .full_out(full_out_s), .we_out(we_out_s), .data_out(data_out_s),
    .pkt_dst_router(pkt_dst_router_s), .next_router(next_router), .grant_id(grant_id_s),
    .busy(busy_s), .drop_count(drop_count_s)
  );

  task automatic check(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle 1 time unit so registered outputs are stable.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_rd_in", AW'(rd_in), AW'(4'b0000));
    check("rst_we_out", AW'(we_out), AW'(3'b000));
    check("rst_data_out", data_out, '0);
    check("rst_pkt_dst", AW'(pkt_dst_router), '0);
    check("rst_grant", AW'(grant_id), '0);
    check("rst_busy", AW'(busy), '0);
    check("rst_drops", AW'(drop_count), '0);

    // Single ACK packet: src=1, dest field 2, next_router=2 -> port 2
    src_router  = 2'd1;
    next_router = 2'd2;
    empty_in    = 4'b1110;
    step();
    check("t1_rd_in", AW'(rd_in), AW'(4'b0001));
    check("t1_busy", AW'(busy), AW'(1'b1));
    empty_in = 4'hF;
    step();
    check("t1_rd_clear", AW'(rd_in), AW'(4'b0000));
    step();
    check("t1_pkt_dst", AW'(pkt_dst_router), AW'(2'd2));
    step();
    check("t1_no_we_early", AW'(we_out), AW'(3'b000));
    step();
    check("t1_we_out", AW'(we_out), AW'(3'b100));
    check("t1_data_out", data_out, pkt[0]);
    check("t1_drops", AW'(drop_count), '0);
    check("t1_idle", AW'(busy), AW'(1'b0));
    step();
    check("t1_data_zero", data_out, '0);

    // All four FIFOs non-empty: grants 0,1,2,3,0,1,2,3 every 5 cycles
    do_reset();
    empty_in = 4'b0000;
    for (int k = 0; k < 8; k++) begin
      step();
      check("t2_rd_in", AW'(rd_in), AW'(4'b0001 << (k % 4)));
      check("t2_grant", AW'(grant_id), AW'(k % 4));
      if (k > 0) check("t2_rd_gap", AW'(cyc - last_rd), AW'(5));
      last_rd = cyc;
      repeat (3) step();
      step();
      check("t2_we_out", AW'(we_out), AW'(3'b100));
      check("t2_data_out", data_out, pkt[k % 4]);
    end
    empty_in = 4'hF;

    // Local packet held by full_out[0] for 10 SEND cycles
    do_reset();
    next_router = 2'd1;
    empty_in    = 4'b1101;
    step();
    check("t3_rd_in", AW'(rd_in), AW'(4'b0010));
    empty_in = 4'hF;
    full_out = 3'b001;
    repeat (3) step();
    for (int k = 0; k < 10; k++) begin
      step();
      check("t3_stalled_we", AW'(we_out), AW'(3'b000));
    end
    check("t3_busy_stalled", AW'(busy), AW'(1'b1));
    full_out = 3'b000;
    step();
    check("t3_we_out", AW'(we_out), AW'(3'b001));
    check("t3_data_out", data_out, pkt[1]);
    check("t3_drops", AW'(drop_count), '0);

    // Port 1 held full with STALL_LIMIT=4 (second instance): drop after 4 SEND cycles
    do_reset();
    next_router = 2'd0;
    full_out_s  = 3'b010;
    empty_in    = 4'b1110;
    step();
    check("t4_rd_in", AW'(rd_in_s), AW'(4'b0001));
    empty_in = 4'hF;
    repeat (3) step();
    for (int k = 0; k < 3; k++) begin
      step();
      check("t4_stall_we", AW'(we_out_s), AW'(3'b000));
      check("t4_stall_busy", AW'(busy_s), AW'(1'b1));
    end
    step();
    check("t4_drop_we", AW'(we_out_s), AW'(3'b000));
    check("t4_drop_busy", AW'(busy_s), AW'(1'b0));
    check("t4_drop_count", AW'(drop_count_s), AW'(16'd1));
    full_out_s = 3'b000;

    // Unroutable: src=0, next_router=2 -> drop in ROUTE, then grant port0
    do_reset();
    src_router  = 2'd0;
    next_router = 2'd2;
    empty_in    = 4'b1100;
    step();
    check("t5_grant0", AW'(grant_id), AW'(2'd0));
    step();
    step();
    check("t5_pkt_dst", AW'(pkt_dst_router), AW'(2'd2));
    check("t5_no_drop_yet", AW'(drop_count), '0);
    step();
    check("t5_drop_count", AW'(drop_count), AW'(16'd1));
    check("t5_busy", AW'(busy), AW'(1'b0));
    check("t5_no_we", AW'(we_out), AW'(3'b000));
    step();
    check("t5_next_grant", AW'(grant_id), AW'(2'd1));
    check("t5_next_rd", AW'(rd_in), AW'(4'b0010));
    empty_in = 4'hF;

    // Reset during WAIT, then grant restarts from ptr=0
    do_reset();
    src_router  = 2'd1;
    next_router = 2'd2;
    empty_in    = 4'b1011;
    step();
    check("t6_grant2", AW'(grant_id), AW'(2'd2));
    empty_in = 4'hF;
    step();
    rst = 1'b1;
    step();
    check("t6_rst_rd", AW'(rd_in), AW'(4'b0000));
    check("t6_rst_we", AW'(we_out), AW'(3'b000));
    check("t6_rst_data", data_out, '0);
    check("t6_rst_dst", AW'(pkt_dst_router), '0);
    check("t6_rst_grant", AW'(grant_id), '0);
    check("t6_rst_busy", AW'(busy), '0);
    check("t6_rst_drops", AW'(drop_count), '0);
    rst      = 1'b0;
    empty_in = 4'b0000;
    step();
    check("t6_ptr0_grant", AW'(grant_id), AW'(2'd0));
    check("t6_ptr0_rd", AW'(rd_in), AW'(4'b0001));
    empty_in = 4'hF;
    repeat (6) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/switch_rr_scheduler.md
# switch_rr_scheduler

Round-robin scheduler and output-flow controller for one router switch. It arbitrates four input FIFOs: the ACK FIFO and input ports 0–2. It pops one packet at a time, captures it, and resolves its destination through the routing table. It then writes the packet to output port 0 (local), 1 (src−1) or 2 (src+1) only when that output FIFO is not full. Packets that cannot be routed, or that stall too long, are dropped and counted.

## Interface
- ROUTER_WIDTH, 2, router ID width; destination field is data[ROUTER_WIDTH+1:2]
- AURORA_WIDTH, 256, packet width
- RD_LATENCY, 1, cycles from FIFO read pulse to valid read data (≥1)
- STALL_LIMIT, 255, max SEND cycles spent waiting on a full output before the packet is dropped (≥1)

- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- src_router  in  ROUTER_WIDTH  this router's ID
- empty_in  in  4  FIFO empty flags; bit0=ACK, bit1=port0, bit2=port1, bit3=port2
- rd_in  out  4  one-hot read pulse, same bit mapping
- data_in  in  4*AURORA_WIDTH  FIFO read data; slice i = bits [i*AURORA_WIDTH +: AURORA_WIDTH]
- full_out  in  3  output FIFO full flags, ports 0..2
- we_out  out  3  output write enables, ports 0..2
- data_out  out  AURORA_WIDTH  data shared by all output ports
- pkt_dst_router  out  ROUTER_WIDTH  destination of captured packet, to routing table
- next_router  in  ROUTER_WIDTH  routing-table answer for pkt_dst_router (combinational)
- grant_id  out  2  index of the currently or last granted requester
- busy  out  1  high whenever state ≠ IDLE
- drop_count  out  16  saturating count of dropped packets

## Operation
- States: IDLE, READ, WAIT, ROUTE, SEND.
- IDLE: search the non-empty requesters in round-robin order, starting at ptr.
  - If a requester is found, set grant_id to it, pulse its rd_in bit, and go to READ.
  - ptr becomes grant_id+1 mod 4.
- READ: lasts 1 cycle, with rd_in[grant_id]=1 only in this cycle. Load wait counter; go to WAIT.
- WAIT: lasts RD_LATENCY cycles.
  - On the last WAIT cycle, data_reg ← data_in slice grant_id; go to ROUTE.
- ROUTE: pkt_dst_router = data_reg[ROUTER_WIDTH+1:2], with next_router valid in the same cycle. Register the target using mod-2^ROUTER_WIDTH arithmetic:
  - next_router == src_router+1 → port 2
  - else next_router == src_router−1 → port 1
  - else next_router == src_router → port 0
  - else no target → drop, return to IDLE
  - Priority follows the order above (relevant when ROUTER_WIDTH=1 makes +1 == −1).
- SEND: each cycle, sample full_out[target].
  - Not full: at the next edge, we_out[target]=1 and data_out=data_reg for one cycle; go to IDLE.
  - Full: increment stall_cnt. If stall_cnt reaches STALL_LIMIT, drop and go to IDLE.
- Drop: drop_count+1, saturating at 16'hFFFF; no write is issued.
- Only one packet is in flight at a time. No new rd_in is issued until the current packet has been written or dropped.
- empty_in is sampled only in IDLE. A FIFO that goes non-empty during the other states is served in later IDLE cycles, in round-robin order.

## Timing
- Reset values: state=IDLE, ptr=0, rd_in=0, we_out=0, data_out=0, pkt_dst_router=0 (data_reg=0), grant_id=0, busy=0, drop_count=0, stall_cnt=0.
- All outputs are registered except pkt_dst_router, which is a decode of data_reg, and busy, which is a decode of state.
- Uncongested path with request seen in IDLE at cycle t:
  - rd_in at t+1
  - data sampled at t+1+RD_LATENCY
  - ROUTE at t+2+RD_LATENCY
  - SEND at t+3+RD_LATENCY
  - we_out at t+4+RD_LATENCY, the same cycle the state returns to IDLE
- Back-to-back throughput: one packet per 4+RD_LATENCY cycles.
- data_out is 0 in every cycle where we_out is 0.
- Starvation bound: a non-empty requester is granted within 3 other grants.
- Reset asserted mid-packet: everything returns to reset values at the next edge. A packet already popped is lost and is not counted as a drop.
- rst has priority over every other event in the same cycle.

## Test plan
- Single ACK packet, src_router=1, dest field=2, next_router=2, RD_LATENCY=1:
  - rd_in=4'b0001 at t+1
  - we_out=3'b100 at t+5
  - data_out equals the packet; drop_count=0
- All four FIFOs non-empty for 8 packets:
  - grant_id sequence is 0,1,2,3,0,1,2,3
  - consecutive rd_in pulses are exactly 5 cycles apart
- full_out[0]=1 for 10 cycles during a local (port 0) packet, STALL_LIMIT=255:
  - we_out[0] asserts on the cycle after full_out[0] drops
  - no drop
- full_out[1] held at 1 with STALL_LIMIT=4: no we_out, drop_count increments to 1, busy falls.
- src_router=0, next_router=2 with ROUTER_WIDTH=2 (unroutable): drop_count=1 directly from ROUTE, and the next IDLE grants the following requester.
- rst pulsed during WAIT: outputs at reset values the next cycle, and the following grant starts from ptr=0.
